mem_stage: RTL

Memory-access stage of the five-stage RV32I pipeline, between the EX/MEM and MEM/WB pipeline registers. It consumes the `exmem_t` bundle produced by the execute stage and drives a variable-latency data-memory port with a req/ready handshake. It performs byte/halfword/word store lane steering and load extraction with sign/zero extension. It stalls the pipeline while an access is outstanding and emits the `memwb_t` bundle for writeback.

---
 rtl/pipeline_pkg.sv | 40 ++++
 rtl/load_store_align.sv | 48 ++++
 rtl/mem_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline-register bundles, memory-stage FSM states and load/store size codes.
package pipeline_pkg;

    typedef struct packed {
        logic [31:0] ALUResult;
        logic [31:0] WriteData;
        logic [2:0]  funct3;
        logic        MemWrite;
        logic [1:0]  ResultSrc;
        logic        RegWrite;
        logic [4:0]  Rd;
        logic [31:0] PCPlus4;
        logic [31:0] ImmExt;
    } exmem_t;

    typedef struct packed {
        logic [31:0] ALUResult;
        logic [31:0] ReadData;
        logic [31:0] PCPlus4;
        logic [31:0] ImmExt;
        logic [4:0]  Rd;
        logic        RegWrite;
        logic [1:0]  ResultSrc;
    } memwb_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering for stores, load extraction with sign/zero
// extension, and misalignment detection from the low address bits.
module load_store_align
    import pipeline_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [15:0] shifted;

    always_comb begin
        shifted    = 16'(load_word >> {offset, 3'b000});
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = 1'b0;
        load_data  = load_word;

        // funct3[1:0] encodes the access size for both loads and stores
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << offset;
                wdata      = {2{store_data[15:0]}};
                misaligned = offset[0];
            end
            default: misaligned = (offset != 2'b00);
        endcase

        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted};
            F3_BU:   load_data = {24'd0, shifted[7:0]};
            F3_HU:   load_data = {16'd0, shifted};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: drives a variable-latency data port, stalls the
// front of the pipeline while an access is outstanding, and builds the MEM/WB bundle.
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        reset,
    input  exmem_t      inputs,
    input  logic        StallExt,
    output memwb_t      outputs,
    output logic        StallM,
    output logic        MisalignedM,
    output logic        BusErrM,
    output logic [4:0]  RdM,
    output logic [31:0] ALUResultM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready
);

    // The counter holds completed WAIT cycles, so the current one is number cnt+1.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_state_t  state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] capture_q, capture_d;

    logic        is_load, is_store, access, misaligned, timeout;
    logic [31:0] load_data, read_data;
    logic        reg_write;

    assign is_store = inputs.MemWrite;
    assign is_load  = (inputs.ResultSrc == RESULT_SRC_MEM) && !inputs.MemWrite;
    assign access   = is_load || is_store;
    assign timeout  = (state_q == WAIT) && (wait_cnt_q == TIMEOUT_LAST);

    load_store_align u_align (
        .offset     (inputs.ALUResult[1:0]),
        .funct3     (inputs.funct3),
        .store_data (inputs.WriteData),
        .load_word  (dmem_rdata),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    assign dmem_we   = is_store;
    assign dmem_addr = {inputs.ALUResult[31:2], 2'b00};

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        capture_d   = capture_q;
        dmem_req    = 1'b0;
        StallM      = 1'b0;
        MisalignedM = 1'b0;
        BusErrM     = 1'b0;
        read_data   = 32'd0;
        reg_write   = inputs.RegWrite;

        case (state_q)
            IDLE: begin
                if (access && misaligned) begin
                    MisalignedM = 1'b1;
                    reg_write   = 1'b0;
                end else if (access) begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        read_data = is_load ? load_data : 32'd0;
                        if (StallExt) begin
                            state_d   = HOLD;
                            capture_d = read_data;
                        end
                    end else begin
                        StallM     = 1'b1;
                        state_d    = WAIT;
                        wait_cnt_d = 8'd0;
                    end
                end
            end
            WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    read_data = is_load ? load_data : 32'd0;
                    if (StallExt) begin
                        state_d   = HOLD;
                        capture_d = read_data;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timeout) begin
                    dmem_req  = 1'b0;
                    BusErrM   = 1'b1;
                    reg_write = 1'b0;
                    state_d   = IDLE;
                end else begin
                    StallM     = 1'b1;
                    wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
                end
            end
            HOLD: begin
                // The access already completed; replay the captured data, never reissue.
                read_data = capture_q;
                if (!StallExt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= 8'd0;
            capture_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            capture_q  <= capture_d;
        end
    end

    always_comb begin
        outputs.ALUResult = inputs.ALUResult;
        outputs.ReadData  = read_data;
        outputs.PCPlus4   = inputs.PCPlus4;
        outputs.ImmExt    = inputs.ImmExt;
        outputs.Rd        = inputs.Rd;
        outputs.RegWrite  = reg_write;
        outputs.ResultSrc = inputs.ResultSrc;
    end

    assign RdM        = inputs.Rd;
    assign ALUResultM = inputs.ALUResult;

endmodule
